// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: widths, reset/bubble constants, opcodes,
// the IF/ID register layout and a word-alignment helper.
package rv32_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0]  OP_BRANCH        = 7'b110_0011;
  localparam logic [6:0]  OP_JAL           = 7'b110_1111;
  localparam logic [6:0]  OP_JALR          = 7'b110_0111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Clear the two low address bits so every fetch is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] i_addr);
    return {i_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/adder32.sv
// Plain 32-bit modulo adder used for PC increment.
module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// fills the IF/ID register. Redirects from EX restart fetch at the aligned
// target; a hazard stall re-issues the last address so no skid buffer is needed.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_pc_sel,
  input  logic [31:0] i_pc_target,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_pc4,
  output logic [31:0] o_ifid_instr,
  output logic        o_ifid_valid,
  output logic        o_misalign
);

  import rv32_pkg::*;

  logic [31:0] r_pc;          // next address to issue
  logic [31:0] r_rsp_pc;      // address issued last cycle
  logic [31:0] r_rsp_pc4;     // its link value, carried to avoid a second adder
  logic        r_rsp_valid;
  ifid_t       r_ifid;
  logic        r_misalign;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_base;
  logic [31:0] w_pc_plus4;
  logic        w_unused_tgt0;

  // JALR semantics: bit 0 of the target is dropped, bit 1 only raises misalign.
  assign w_tgt         = align_word(i_pc_target);
  assign w_unused_tgt0 = i_pc_target[0];

  // Adder operand: the redirect target on a taken branch, otherwise the current PC.
  always_comb begin
    w_pc_base = r_pc;
    if (i_pc_sel) begin
      w_pc_base = w_tgt;
    end else begin
      w_pc_base = r_pc;
    end
  end

  adder32 u_pc_adder (
    .i_a   (w_pc_base),
    .i_b   (32'd4),
    .o_sum (w_pc_plus4)
  );

  // Fetch address: reset > redirect (same-cycle target) > stall (re-issue) > sequential.
  always_comb begin
    o_imem_addr = r_pc;
    if (i_reset) begin
      o_imem_addr = RESET_PC;
    end else if (i_pc_sel) begin
      o_imem_addr = w_tgt;
    end else if (i_stall) begin
      o_imem_addr = r_rsp_pc;
    end else begin
      o_imem_addr = r_pc;
    end
  end

  // PC, in-flight response tracking, IF/ID register and misalign pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc           <= RESET_PC;
      r_rsp_pc       <= RESET_PC;
      r_rsp_pc4      <= 32'h0000_0000;
      r_rsp_valid    <= 1'b0;
      r_ifid.pc      <= 32'h0000_0000;
      r_ifid.pc4     <= 32'h0000_0000;
      r_ifid.instr   <= NOP_INSTR;
      r_ifid.valid   <= 1'b0;
      r_misalign     <= 1'b0;
    end else begin
      r_misalign <= i_pc_sel & i_pc_target[1];
      if (i_pc_sel) begin
        // Redirect wins over stall; the wrong-path word returning now is dropped.
        r_pc         <= w_pc_plus4;
        r_rsp_pc     <= w_tgt;
        r_rsp_pc4    <= w_pc_plus4;
        r_rsp_valid  <= 1'b1;
        r_ifid.instr <= NOP_INSTR;
        r_ifid.valid <= 1'b0;
      end else if (i_stall) begin
        // Hold everything; the re-issued address returns on the first free cycle.
        r_pc         <= r_pc;
        r_rsp_pc     <= r_rsp_pc;
        r_rsp_pc4    <= r_rsp_pc4;
        r_rsp_valid  <= r_rsp_valid;
        r_ifid       <= r_ifid;
      end else begin
        r_pc         <= w_pc_plus4;
        r_rsp_pc     <= r_pc;
        r_rsp_pc4    <= w_pc_plus4;
        r_rsp_valid  <= 1'b1;
        if (r_rsp_valid) begin
          r_ifid.pc    <= r_rsp_pc;
          r_ifid.pc4   <= r_rsp_pc4;
          r_ifid.instr <= i_imem_rdata;
          r_ifid.valid <= 1'b1;
        end else begin
          r_ifid.instr <= NOP_INSTR;
          r_ifid.valid <= 1'b0;
        end
      end
    end
  end

  assign o_ifid_pc    = r_ifid.pc;
  assign o_ifid_pc4   = r_ifid.pc4;
  assign o_ifid_instr = r_ifid.instr;
  assign o_ifid_valid = r_ifid.valid;
  assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a 1-cycle synchronous imem model returns
// address-derived words; each step pushes the IF/ID/misalign values expected
// after the next edge onto a scoreboard queue, which is popped and compared.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misalign;

  int tests;
  int fails;

  typedef struct {
    logic        valid;
    logic        chk_pc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  if_fetch_stage dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_pc_sel     (pc_sel),
    .i_pc_target  (pc_target),
    .o_imem_addr  (imem_addr),
    .i_imem_rdata (imem_rdata),
    .o_ifid_pc    (ifid_pc),
    .o_ifid_pc4   (ifid_pc4),
    .o_ifid_instr (ifid_instr),
    .o_ifid_valid (ifid_valid),
    .o_misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) imem_rdata <= mk(imem_addr);

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check fetch address, then check IF/ID after the edge.
  task automatic step(input string tag, input logic rst, input logic st, input logic sel,
                      input logic [31:0] tgt, input logic [31:0] e_addr,
                      input logic e_v, input logic [31:0] e_pc, input logic e_mis);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset     = rst;
    stall     = st;
    pc_sel    = sel;
    pc_target = tgt;
    #1;
    chk32({tag, ".addr"}, imem_addr, e_addr);
    e.valid  = e_v;
    e.chk_pc = e_v | rst;
    e.pc     = e_pc;
    e.pc4    = rst ? 32'h0000_0000 : e_pc + 32'd4;
    e.instr  = e_v ? mk(e_pc) : NOP;
    e.mis    = e_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk1({tag, ".valid"}, ifid_valid, got.valid);
    chk32({tag, ".instr"}, ifid_instr, got.instr);
    chk1({tag, ".misalign"}, misalign, got.mis);
    if (got.chk_pc) begin
      chk32({tag, ".pc"}, ifid_pc, got.pc);
      chk32({tag, ".pc4"}, ifid_pc4, got.pc4);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    pc_sel    = 1'b0;
    pc_target = 32'h0000_0000;

    // Reset state, with a redirect request that must be ignored.
    step("rst0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst1", 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 1'b0, 32'h0, 1'b0);

    // Sequential fetch: first valid IF/ID two edges after release.
    step("seq0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    step("seq1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);
    step("seq2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0);
    step("seq3", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0);

    // Three-cycle stall: IF/ID holds pc=8, address 12 re-issued.
    step("stl0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0);
    step("stl1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0);
    step("stl2", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0);
    step("rel0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0);
    step("rel1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0014, 1'b1, 32'h0000_0010, 1'b0);

    // Redirect to 0x100: same-cycle fetch, bubble, then target stream.
    step("red0", 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
    step("red1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0104, 1'b1, 32'h0000_0100, 1'b0);
    step("red2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0108, 1'b1, 32'h0000_0104, 1'b0);

    // Redirect with stall to a misaligned target: redirect wins, misalign pulses.
    step("rs0", 1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
    step("rs1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0204, 1'b1, 32'h0000_0200, 1'b0);
    step("rs2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0208, 1'b1, 32'h0000_0204, 1'b0);

    // Mid-stream reset with a redirect: reset wins, fetch restarts at RESET_PC.
    step("mrst", 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    step("mr0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    step("mr1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);

    // PC wrap at the top of the address space.
    step("wrp0", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    step("wrp1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step("wrp2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);

    // Target with only bit 0 set: aligned fetch, no misalign.
    step("b0_0", 1'b0, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_0400, 1'b0, 32'h0, 1'b0);
    step("b0_1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0404, 1'b1, 32'h0000_0400, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
